// File: rtl/ib_down_output_buffer_if.sv
// Purpose : word-level bus of the 8-bit downstream internal bus (data, SOP/EOP, active-low handshake).
// Latency : none, signal bundle only.
// Backpressure: dst_rdy_n from the sink stalls the source; a word moves when src_rdy_n=0 and dst_rdy_n=0.
//
// Modports: master drives data/sop_n/eop_n/src_rdy_n and samples dst_rdy_n; slave is the mirror.
interface ib_down_output_buffer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  sop_n;
    logic                  eop_n;
    logic                  src_rdy_n;
    logic                  dst_rdy_n;

    modport master (output data, output sop_n, output eop_n, output src_rdy_n, input dst_rdy_n);
    modport slave  (input data, input sop_n, input eop_n, input src_rdy_n, output dst_rdy_n);
endinterface

// File: rtl/ib_down_output_buffer.sv
// Purpose : framed FIFO between the internal bus transformer down port and the 8-bit endpoint; flags input framing errors.
// Latency : a word accepted on edge n is visible on out_bus after edge n (earliest read on edge n+1); no pass-through.
// Backpressure: in_bus.dst_rdy_n=1 only when full, out_bus.src_rdy_n=1 only when empty; both from registered count.
//
// Ports: clk, rst (async, active high); in_bus (slave: words from the transformer);
//        out_bus (master: words to the endpoint); frame_err (sticky framing violation);
//        pkt_cnt (EOP words delivered, only counts when IB_DOWN_BUF_STATS_EN is defined, else tied to 0).
module ib_down_output_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ITEMS      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    ib_down_output_buffer_if.slave  in_bus,
    ib_down_output_buffer_if.master out_bus,
    output logic                    frame_err,
    output logic [15:0]             pkt_cnt
);
    localparam int CNT_W = $clog2(ITEMS + 1);
    localparam int PTR_W = (ITEMS > 1) ? $clog2(ITEMS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ITEMS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ITEMS);

    // Framing flags are stored active high; inversion happens at the output.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
    } entry_t;

    typedef enum logic {IDLE, IN_PKT} state_t;

    entry_t           mem [ITEMS];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;
    logic             in_sop;
    logic             in_eop;
    state_t           state;
    state_t           state_nxt;
    logic             err_set;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign in_sop = ~in_bus.sop_n;
    assign in_eop = ~in_bus.eop_n;

    // A full buffer refuses writes even when a read frees a slot this cycle,
    // keeping the input handshake independent of the output side.
    assign wr_en = ~in_bus.src_rdy_n & ~full;
    assign rd_en = ~empty & ~out_bus.dst_rdy_n;

    assign in_bus.dst_rdy_n  = full;
    assign out_bus.src_rdy_n = empty;
    assign out_bus.data      = mem[rd_ptr].data;
    assign out_bus.sop_n     = ~mem[rd_ptr].sop;
    assign out_bus.eop_n     = ~mem[rd_ptr].eop;

    // Storage is cleared on reset so the output word returns to data 0, SOP/EOP inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ITEMS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= '{data: in_bus.data, sop: in_sop, eop: in_eop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Framing checker: only accepted words advance it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err_set) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        if (wr_en) begin
            case (state)
                IDLE: begin
                    // Missing SOP is flagged but the word still opens a packet.
                    err_set   = ~in_sop;
                    state_nxt = in_eop ? IDLE : IN_PKT;
                end
                IN_PKT: begin
                    // SOP inside a packet is flagged and restarts the packet.
                    err_set   = in_sop;
                    state_nxt = in_eop ? IDLE : IN_PKT;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef IB_DOWN_BUF_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (rd_en && mem[rd_ptr].eop) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`else
    assign pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_ib_down_output_buffer.sv
module tb_ib_down_output_buffer;
    localparam int DW    = 8;
    localparam int ITEMS = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_err;
    logic [15:0] pkt_cnt;

    ib_down_output_buffer_if #(.DATA_WIDTH(DW)) in_if ();
    ib_down_output_buffer_if #(.DATA_WIDTH(DW)) out_if ();

    ib_down_output_buffer #(.DATA_WIDTH(DW), .ITEMS(ITEMS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_if),
        .out_bus   (out_if),
        .frame_err (frame_err),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: accepted words queue up in order; framing follows packet state.
    word_t       exp_q[$];
    logic        exp_err  = 1'b0;
    bit          in_pkt   = 1'b0;
    logic [15:0] exp_pkt  = '0;
    int          pops     = 0;
    int          n_pass   = 0;
    int          n_total  = 0;
    int          cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic note_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Acceptance tracker: the word on in_if when both ready signals are low at
    // the negedge is taken on the next posedge.
    always @(negedge clk) begin
        #1;
        if (!rst && in_if.src_rdy_n == 1'b0 && in_if.dst_rdy_n == 1'b0) begin
            word_t w;
            w.data = in_if.data;
            w.sop  = ~in_if.sop_n;
            w.eop  = ~in_if.eop_n;
            exp_q.push_back(w);
            if (in_pkt == w.sop) exp_err = 1'b1;
            in_pkt = !w.eop;
        end
    end

    // Monitor: compare occupancy flags and status, then pop whatever the DUT delivers.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_empty", out_if.src_rdy_n, exp_q.size() == 0);
            chk("in_full", in_if.dst_rdy_n, exp_q.size() == ITEMS);
            chk("frame_err", frame_err, exp_err);
`ifdef IB_DOWN_BUF_STATS_EN
            chk("pkt_cnt", pkt_cnt, exp_pkt);
`else
            chk("pkt_cnt", pkt_cnt, 16'd0);
`endif
            if (out_if.src_rdy_n == 1'b0 && out_if.dst_rdy_n == 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", out_if.data, $time);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("out_word", {out_if.data, ~out_if.sop_n, ~out_if.eop_n}, {e.data, e.sop, e.eop});
                    if (e.eop) exp_pkt = exp_pkt + 16'd1;
                    pops++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit sop, input bit eop);
        int t;
        in_if.data      = d;
        in_if.sop_n     = !sop;
        in_if.eop_n     = !eop;
        in_if.src_rdy_n = 1'b0;
        t = 0;
        @(negedge clk);
        while (in_if.dst_rdy_n != 1'b0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) note_fail("send");
        @(posedge clk);
        #1;
        in_if.src_rdy_n = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_if.dst_rdy_n = 1'b0;
        while (exp_q.size() != 0 && t < 200) begin
            t++;
            @(posedge clk);
        end
        if (t >= 200) note_fail("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        bit rnd_done;
        in_if.data       = '0;
        in_if.sop_n      = 1'b1;
        in_if.eop_n      = 1'b1;
        in_if.src_rdy_n  = 1'b1;
        out_if.dst_rdy_n = 1'b1;

        // Reset values.
        #1;
        chk("rst_in_rdy", in_if.dst_rdy_n, 1'b0);
        chk("rst_out_vld", out_if.src_rdy_n, 1'b1);
        chk("rst_data", out_if.data, 8'h00);
        chk("rst_sop", out_if.sop_n, 1'b1);
        chk("rst_eop", out_if.eop_n, 1'b1);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_pkt", pkt_cnt, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Fill with downstream stalled, hold a fifth word, one read/refused write, then drain.
        send(8'h11, 1, 0);
        send(8'h22, 0, 0);
        send(8'h33, 0, 0);
        send(8'h44, 0, 1);
        chk("full_after_4", in_if.dst_rdy_n, 1'b1);
        in_if.data = 8'h55; in_if.sop_n = 1'b0; in_if.eop_n = 1'b0; in_if.src_rdy_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_hold", in_if.dst_rdy_n, 1'b1);
        @(posedge clk); #1;
        out_if.dst_rdy_n = 1'b0;
        @(negedge clk);
        chk("rw_refuse", in_if.dst_rdy_n, 1'b1);
        @(posedge clk); #1;
        out_if.dst_rdy_n = 1'b1;
        @(negedge clk);
        chk("accept_next", in_if.dst_rdy_n, 1'b0);
        @(posedge clk); #1;
        in_if.src_rdy_n = 1'b1;
        chk("refull", in_if.dst_rdy_n, 1'b1);
        drain();

        // Streaming single-word packets at full rate.
        t0 = cyc;
        for (int i = 0; i < 20; i++) send(8'(i), 1, 1);
        chk("stream_cycles", cyc - t0, 20);
        drain();
        chk("stream_pops", pops, 25);

        // Framing violations: missing SOP, then SOP inside a packet.
        chk("ferr_before", frame_err, 1'b0);
        send(8'h66, 0, 1);
        #5;
        chk("ferr_nosop", frame_err, 1'b1);
        send(8'h70, 1, 0);
        send(8'h71, 1, 0);
        send(8'h72, 0, 1);
        drain();
        chk("ferr_sticky", frame_err, 1'b1);

        // Randomized traffic with random downstream stalls.
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_if.dst_rdy_n = ($urandom_range(0, 2) == 0);
                end
            end
        join
        drain();

        // Reset mid-packet with three words buffered.
        out_if.dst_rdy_n = 1'b1;
        send(8'h90, 1, 0);
        send(8'h91, 0, 0);
        send(8'h92, 0, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_vld", out_if.src_rdy_n, 1'b1);
        chk("mid_rst_in_rdy", in_if.dst_rdy_n, 1'b0);
        chk("mid_rst_ferr", frame_err, 1'b0);
        chk("mid_rst_pkt", pkt_cnt, 16'd0);
        exp_q.delete();
        exp_err = 1'b0;
        in_pkt  = 1'b0;
        exp_pkt = '0;
        pops    = 0;
        @(negedge clk);
        #3 rst = 1'b0;
        out_if.dst_rdy_n = 1'b0;
        @(posedge clk); #1;
        send(8'hA0, 1, 0);
        send(8'hA1, 0, 1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_pops", pops, 2);
        chk("post_rst_ferr", frame_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
